coin_pulse_gen: RTL

- Front end of the coin path. Converts the asynchronous, bouncy nickel and dime sensor lines into clean, single-cycle, mutually exclusive D/N pulses.
- These pulses drive the vending-machine Mealy FSM directly.
- Also flags jammed sensors and discards coins while acceptance is disabled.

---
 rtl/coin_pulse_gen_pkg.sv | 14 +
 rtl/coin_pulse_gen_if.sv | 25 ++
 rtl/coin_pulse_gen_debounce.sv | 85 ++++++++
 rtl/coin_pulse_gen.sv | 97 +++++++++
 4 files changed

// File: rtl/coin_pulse_gen_pkg.sv
// Shared definitions for the coin front end: default timing parameters
// and the output-select encoding used by the pulse arbiter.
package coin_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_JAM_CYCLES      = 1000;

  typedef enum logic [1:0] {
    COIN_NONE   = 2'd0,
    COIN_NICKEL = 2'd1,
    COIN_DIME   = 2'd2
  } coin_e;

endpackage

// File: rtl/coin_pulse_gen_if.sv
// Coin front-end signal bundle: raw sensors and accept enable in,
// clean coin pulses and status out. Clock and reset travel separately.
interface coin_pulse_gen_if;

  logic nickel_raw;
  logic dime_raw;
  logic accept_en;
  logic D;
  logic N;
  logic jam;
  logic reject;

  // Stimulus side (sensors / controller)
  modport master (
    output nickel_raw, dime_raw, accept_en,
    input  D, N, jam, reject
  );

  // Coin front-end side
  modport slave (
    input  nickel_raw, dime_raw, accept_en,
    output D, N, jam, reject
  );

endinterface

// File: rtl/coin_pulse_gen_debounce.sv
// One sensor channel: 2-flop synchronizer, level debouncer, rising-edge
// detect (asserted in the cycle before the debounced level goes high) and
// a saturating jam timer.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int JAM_CYCLES      = DEF_JAM_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic rise,
  output logic jam
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int                JAM_W   = $clog2(JAM_CYCLES + 1);
  localparam logic [JAM_W-1:0]  JAM_MAX = JAM_W'(JAM_CYCLES);
  localparam logic [JAM_W-1:0]  JAM_PRE = JAM_W'(JAM_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic [JAM_W-1:0] r_jam_cnt;
  logic             r_jam;

  logic             w_flip;
  logic             w_rise;
  logic             w_fall;

  // The debounced level changes on the next edge when the disagreement
  // has already lasted DEBOUNCE_CYCLES-1 cycles.
  assign w_flip = (r_s2 != r_db) && (r_cnt == CNT_MAX);
  assign w_rise = w_flip &  r_s2;
  assign w_fall = w_flip & ~r_s2;

  assign rise = w_rise;
  assign jam  = r_jam;

  // Two-flop synchronizer, nothing between the stages
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
    end
  end

  // Debounce: accept a new level only after it holds DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (r_s2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_db  <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Jam timer: count debounced-high cycles, flag at JAM_CYCLES, clear on release
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_jam_cnt <= '0;
      r_jam     <= 1'b0;
    end else if (w_fall) begin
      r_jam_cnt <= '0;
      r_jam     <= 1'b0;
    end else if (r_db && (r_jam_cnt != JAM_MAX)) begin
      r_jam_cnt <= r_jam_cnt + 1'b1;
      if (r_jam_cnt == JAM_PRE) begin
        r_jam <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_pulse_gen.sv
// Coin front end top: two debounced sensor channels feeding a one-pulse-
// per-cycle arbiter. Dime wins a tie; the loser waits in a one-deep pending
// flag and has priority next cycle. Pulses issued while accept_en is low
// come out as reject instead of D/N.
module coin_pulse_gen
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int JAM_CYCLES      = DEF_JAM_CYCLES
) (
  input logic              clk,
  input logic              rstn,
  coin_pulse_gen_if.slave  bus
);

  logic  w_rise_n;
  logic  w_rise_d;
  logic  w_jam_n;
  logic  w_jam_d;

  coin_e w_sel;
  logic  w_pend_n_nxt;
  logic  w_pend_d_nxt;

  logic  r_pend_n;
  logic  r_pend_d;
  logic  r_d;
  logic  r_n;
  logic  r_reject;

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_nickel (
    .clk  (clk),
    .rstn (rstn),
    .raw  (bus.nickel_raw),
    .rise (w_rise_n),
    .jam  (w_jam_n)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_dime (
    .clk  (clk),
    .rstn (rstn),
    .raw  (bus.dime_raw),
    .rise (w_rise_d),
    .jam  (w_jam_d)
  );

  // Arbitration: pending entries first, then a new dime, then a new nickel;
  // any event not issued this cycle is parked in its pending flag.
  always_comb begin
    w_sel        = COIN_NONE;
    w_pend_n_nxt = r_pend_n;
    w_pend_d_nxt = r_pend_d;
    if (r_pend_d) begin
      w_sel        = COIN_DIME;
      w_pend_d_nxt = w_rise_d;
      w_pend_n_nxt = r_pend_n | w_rise_n;
    end else if (r_pend_n) begin
      w_sel        = COIN_NICKEL;
      w_pend_n_nxt = w_rise_n;
      w_pend_d_nxt = w_rise_d;
    end else if (w_rise_d) begin
      w_sel        = COIN_DIME;
      w_pend_n_nxt = w_rise_n;
    end else if (w_rise_n) begin
      w_sel        = COIN_NICKEL;
    end
  end

  // Registered pulses and pending flags; accept_en applies at issue time
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_n <= 1'b0;
      r_pend_d <= 1'b0;
      r_d      <= 1'b0;
      r_n      <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_pend_n <= w_pend_n_nxt;
      r_pend_d <= w_pend_d_nxt;
      r_d      <= bus.accept_en  && (w_sel == COIN_DIME);
      r_n      <= bus.accept_en  && (w_sel == COIN_NICKEL);
      r_reject <= !bus.accept_en && (w_sel != COIN_NONE);
    end
  end

  assign bus.D      = r_d;
  assign bus.N      = r_n;
  assign bus.reject = r_reject;
  assign bus.jam    = w_jam_n | w_jam_d;

endmodule
